// File: rtl/hilo_mdu.sv
// Iterative radix-2 shift-add multiply / multiply-accumulate unit that owns the
// HI/LO register pair and exposes it as a 64-bit operand for the ALU.
module hilo_mdu #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               wr_hi,
   input  logic               wr_lo,
   input  logic [WIDTH-1:0]   wr_data,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic [2*WIDTH-1:0] hi_lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   logic [CNT_W-1:0]     count_reg;
   logic [WIDTH-1:0]     mcand_reg;
   logic [WIDTH-1:0]     mplier_reg;
   logic [2*WIDTH-1:0]   prod_reg;
   logic                 neg_reg;
   logic                 accum_reg;
   logic [WIDTH-1:0]     hi_reg;
   logic [WIDTH-1:0]     lo_reg;

   // Operand conditioning: signed ops work on magnitudes; the most negative
   // value negates to itself, which is exactly its unsigned magnitude.
   logic                 op_signed;
   logic                 op_accum;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic                 neg_in;

   assign op_signed = ~op[1];
   assign op_accum  = op[0] ^ op[1];
   assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
   assign neg_in    = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

   // Log shifter positions the multiplicand at the current bit weight.
   logic [2*WIDTH-1:0]   shift_stage [0:CNT_W];

   assign shift_stage[0] = {{WIDTH{1'b0}}, mcand_reg};

   generate
      for (genvar gi = 0; gi < CNT_W; gi++) begin : g_shift
         assign shift_stage[gi+1] = count_reg[gi] ? (shift_stage[gi] << (2**gi))
                                                  : shift_stage[gi];
      end
   endgenerate

   logic [2*WIDTH-1:0]   prod_sum;
   logic [2*WIDTH-1:0]   prod_signed;
   logic [2*WIDTH-1:0]   commit_val;

   assign prod_sum    = prod_reg + shift_stage[CNT_W];
   assign prod_signed = neg_reg ? -prod_reg : prod_reg;
   assign commit_val  = accum_reg ? ({hi_reg, lo_reg} + prod_signed) : prod_signed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = CALC;
         CALC: if (count_reg == CNT_LAST) state_next = ACC;
         ACC:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         CALC, ACC: busy = 1'b1;
         DONE:      done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         prod_reg   <= '0;
         neg_reg    <= 1'b0;
         accum_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  mcand_reg  <= a_mag;
                  mplier_reg <= b_mag;
                  neg_reg    <= neg_in;
                  accum_reg  <= op_accum;
                  prod_reg   <= '0;
                  count_reg  <= '0;
               end
            end
            CALC: begin
               if (mplier_reg[0]) prod_reg <= prod_sum;
               mplier_reg <= mplier_reg >> 1;
               count_reg  <= count_reg + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   // HI/LO change only on commit or on an mthi/mtlo accepted outside busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (state_reg == ACC) begin
         {hi_reg, lo_reg} <= commit_val;
      end else if (state_reg == IDLE || state_reg == DONE) begin
         if (wr_hi) hi_reg <= wr_data;
         if (wr_lo) lo_reg <= wr_data;
      end
   end

   assign hi    = hi_reg;
   assign lo    = lo_reg;
   assign hi_lo = {hi_reg, lo_reg};

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: each task drives one scenario and checks its
// own hand-computed results.
module tb_hilo_mdu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wr_data = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [63:0] hi_lo;

   int vectors = 0;
   int miscompares = 0;

   hilo_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .hi_lo(hi_lo)
   );

   always #5 clk = ~clk;

   // mthi/mtlo write for one edge
   task automatic mt(input bit h, input bit l, input logic [31:0] d);
      wr_hi = h; wr_lo = l; wr_data = d;
      @(posedge clk); #1;
      wr_hi = 1'b0; wr_lo = 1'b0;
   endtask

   // Issue one op; wr_edge = edge index (0 = start edge) carrying an mtlo of wr_val.
   // Returns with the unit back in IDLE (one edge after done).
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int wr_edge, input logic [31:0] wr_val,
                         output int lat, output int busy_cnt);
      op = o; a = x; b = y; start = 1'b1;
      wr_lo = (wr_edge == 0); wr_data = wr_val;
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0;
      lat = 1;
      busy_cnt = busy ? 1 : 0;
      wr_lo = (wr_edge == lat);
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
         wr_lo = (wr_edge == lat);
      end
      wr_lo = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      vectors++;
      if ({hi_lo, busy, done} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_state: hi_lo=%h busy=%b done=%b required all zero", hi_lo, busy, done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_mul();
      int lat, bc;
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, '0, lat, bc);
      $display("mul -3*7: lat=%0d busy=%0d hi_lo=%h", lat, bc, hi_lo);
      vectors++;
      if (lat !== 34) begin
         miscompares++;
         $display("FAIL mul_latency: got %0d required 34", lat);
      end
      vectors++;
      if (bc !== 33) begin
         miscompares++;
         $display("FAIL mul_busy_cycles: got %0d required 33", bc);
      end
      vectors++;
      if (hi_lo !== 64'hFFFF_FFFF_FFFF_FFEB || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         miscompares++;
         $display("FAIL mul_result: got %h (hi=%h lo=%h) required ffffffffffffffeb", hi_lo, hi, lo);
      end
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_one_cycle: done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_madd();
      int lat, bc;
      mt(1'b0, 1'b1, 32'h10);
      mt(1'b1, 1'b0, 32'h0);
      vectors++;
      if (hi_lo !== 64'h0000_0000_0000_0010) begin
         miscompares++;
         $display("FAIL mtlo_mthi: got %h required 0000000000000010", hi_lo);
      end
      run_op(2'b01, 32'd2, 32'd3, -1, '0, lat, bc);
      $display("madd 2*3: hi_lo=%h", hi_lo);
      vectors++;
      if (hi !== 32'h0 || lo !== 32'h16) begin
         miscompares++;
         $display("FAIL madd_pos: got hi=%h lo=%h required 0 16", hi, lo);
      end
      run_op(2'b01, 32'hFFFF_FFFF, 32'h17, -1, '0, lat, bc);
      $display("madd -1*23: hi_lo=%h", hi_lo);
      vectors++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL madd_neg: got hi=%h lo=%h required ffffffff ffffffff", hi, lo);
      end
   endtask

   task automatic test_signedness();
      int lat, bc;
      mt(1'b1, 1'b1, 32'h0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, '0, lat, bc);
      $display("multu ffffffff^2: hi_lo=%h", hi_lo);
      vectors++;
      if (hi_lo !== 64'hFFFF_FFFE_0000_0001) begin
         miscompares++;
         $display("FAIL multu_max: got %h required fffffffe00000001", hi_lo);
      end
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, '0, lat, bc);
      $display("mul -1*-1: hi_lo=%h", hi_lo);
      vectors++;
      if (hi_lo !== 64'h0000_0000_0000_0001) begin
         miscompares++;
         $display("FAIL mul_neg_neg: got %h required 0000000000000001", hi_lo);
      end
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, '0, lat, bc);
      $display("mul min*min: hi_lo=%h", hi_lo);
      vectors++;
      if (hi_lo !== 64'h4000_0000_0000_0000) begin
         miscompares++;
         $display("FAIL mul_min_min: got %h required 4000000000000000", hi_lo);
      end
      run_op(2'b00, 32'h8000_0000, 32'd3, -1, '0, lat, bc);
      $display("mul min*3: hi_lo=%h", hi_lo);
      vectors++;
      if (hi_lo !== 64'hFFFF_FFFE_8000_0000) begin
         miscompares++;
         $display("FAIL mul_min_pos: got %h required fffffffe80000000", hi_lo);
      end
   endtask

   task automatic test_wrap();
      int lat, bc;
      mt(1'b1, 1'b1, 32'hFFFF_FFFF);
      vectors++;
      if (hi_lo !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         miscompares++;
         $display("FAIL dual_write: got %h required ffffffffffffffff", hi_lo);
      end
      run_op(2'b10, 32'd1, 32'd1, -1, '0, lat, bc);
      $display("maddu wrap: hi_lo=%h", hi_lo);
      vectors++;
      if (hi_lo !== 64'h0) begin
         miscompares++;
         $display("FAIL maddu_wrap: got %h required 0000000000000000", hi_lo);
      end
   endtask

   task automatic test_collisions();
      int lat, bc, dones, edges;
      op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
      dones = 0;
      edges = 0;
      while (edges < 45) begin
         @(posedge clk); #1;
         edges++;
         if (done) dones++;
         if (!busy && edges > 1) start = 1'b0;
      end
      start = 1'b0;
      $display("start hammer: dones=%0d hi_lo=%h", dones, hi_lo);
      vectors++;
      if (dones !== 1) begin
         miscompares++;
         $display("FAIL start_while_busy_dones: got %0d required 1", dones);
      end
      vectors++;
      if (hi_lo !== 64'd25) begin
         miscompares++;
         $display("FAIL start_while_busy_result: got %h required 25", hi_lo);
      end
      run_op(2'b00, 32'd5, 32'd5, 5, 32'hAA, lat, bc);
      $display("mtlo during calc: hi_lo=%h", hi_lo);
      vectors++;
      if (lo !== 32'd25 || hi !== 32'd0) begin
         miscompares++;
         $display("FAIL mtlo_dropped: got hi=%h lo=%h required 0 19", hi, lo);
      end
      run_op(2'b10, 32'd1, 32'd1, 0, 32'hAA, lat, bc);
      $display("mtlo with start: hi_lo=%h", hi_lo);
      vectors++;
      if (lo !== 32'hAB || hi !== 32'd0) begin
         miscompares++;
         $display("FAIL mtlo_with_start: got hi=%h lo=%h required 0 ab", hi, lo);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc, dones;
      op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      $display("reset mid-calc: hi_lo=%h busy=%b done=%b", hi_lo, busy, done);
      vectors++;
      if (hi_lo !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abort: hi_lo=%h busy=%b done=%b required 0 0 0", hi_lo, busy, done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL no_done_after_abort: got %0d active cycles required 0", dones);
      end
      run_op(2'b00, 32'd6, 32'd7, -1, '0, lat, bc);
      $display("mul 6*7 after reset: lat=%0d hi_lo=%h", lat, hi_lo);
      vectors++;
      if (lat !== 34 || hi_lo !== 64'd42) begin
         miscompares++;
         $display("FAIL mul_after_reset: lat=%0d hi_lo=%h required 34 42", lat, hi_lo);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_mul();
      test_madd();
      test_signedness();
      test_wrap();
      test_collisions();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
